plic_n: RTL and testbench

// - Parametrised platform-level interrupt controller; successor to the single-source uart/gpio controller.
// - Takes NUM_SRC level interrupt lines and gives each one a per-source gateway (pending/claim/complete).
// - Arbitrates sources by programmable priority against a threshold, then raises the machine external interrupt to the core.
// - Wishbone slave on the peripheral bus; gated by mstatus.MIE and mie.MEIE forwarded from the mem stage.

---
 rtl/plic_n.sv | 203 ++++++++++++++++++++
 tb/tb_plic_n.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/plic_n.sv
// Platform-level interrupt controller: per-source pending/claim/complete gateways, priority arbitration, Wishbone slave.
// Latency: irq_i edge -> pending +1 -> best_id +2 -> interrupt_o +3; bus ack one cycle after cyc&stb, then low for one cycle.
// Backpressure: none; every access is acked. Define PLIC_EDGE_EN to add per-source edge-triggered mode at offset 0x001004.
module plic_n #(
  parameter int          NUM_SRC   = 7,
  parameter int          PRIO_W    = 3,
  parameter logic [31:0] BASE_ADDR = 32'h0C000000
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  input  logic [31:0]        wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_stb_i,
  input  logic               wb_cyc_i,
  output logic               wb_ack_o,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic [31:0]        csr_mstatus_i,
  input  logic [31:0]        csr_mie_i,
  output logic               interrupt_o,
  output logic [30:0]        exc_code_o
);

  typedef enum logic [1:0] {GW_IDLE = 2'd0, GW_PEND = 2'd1, GW_INSVC = 2'd2} gw_e;

  localparam logic [29:0] W_PEND  = 30'h0000400;
  localparam logic [29:0] W_EDGE  = 30'h0000401;
  localparam logic [29:0] W_EN    = 30'h0000800;
  localparam logic [29:0] W_THR   = 30'h0080000;
  localparam logic [29:0] W_CLAIM = 30'h0080001;

  logic               ack_q, ack_d;
  logic [31:0]        dat_q, dat_d;
  logic [PRIO_W-1:0]  prio_q [NUM_SRC];
  logic [PRIO_W-1:0]  prio_d [NUM_SRC];
  gw_e                gw_q   [NUM_SRC];
  gw_e                gw_d   [NUM_SRC];
  logic [NUM_SRC-1:0] en_q, en_d;
  logic [PRIO_W-1:0]  thr_q, thr_d;
  logic [4:0]         best_q, best_d;
  logic               int_q, int_d;

  logic [31:0]        off;
  logic [29:0]        word;
  logic [9:0]         prio_idx;
  logic               sel_prio, fire, wr, rd;
  logic [31:0]        rdata;
  logic [NUM_SRC-1:0] pend, insvc, claim_hit, cmpl_hit, trig, set_pend;
  logic [PRIO_W-1:0]  best_p;
  logic               found;
  logic               unused_bits;

  assign off      = wb_adr_i - BASE_ADDR;
  assign word     = off[31:2];
  assign prio_idx = word[9:0];
  assign sel_prio = (word[29:10] == 20'd0);
  // A transfer commits on the edge that raises ack; a second edge of the same access is blocked by ack_q.
  assign fire     = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr       = fire & wb_we_i;
  assign rd       = fire & ~wb_we_i;
  assign unused_bits = ^{wb_sel_i, wb_dat_i, csr_mstatus_i, csr_mie_i, off[1:0]};

`ifdef PLIC_EDGE_EN
  logic [NUM_SRC-1:0] emode_q, emode_d, prev_q, latch_q, latch_d, rise;

  assign rise = irq_i & ~prev_q;
  assign trig = (emode_q & (rise | latch_q)) | (~emode_q & irq_i);

  always_comb begin
    emode_d = emode_q;
    if (wr && word == W_EDGE) emode_d = wb_dat_i[NUM_SRC-1:0];
    // One-deep memory of an edge seen during service; consumed when the gateway re-pends.
    latch_d = ((latch_q & ~set_pend) | (rise & insvc)) & emode_q;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      emode_q <= '0;
      prev_q  <= '0;
      latch_q <= '0;
    end else begin
      emode_q <= emode_d;
      prev_q  <= irq_i;
      latch_q <= latch_d;
    end
  end
`else
  assign trig = irq_i;
`endif

  // Gateway output decode.
  always_comb begin
    pend  = '0;
    insvc = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      pend[k]  = (gw_q[k] == GW_PEND);
      insvc[k] = (gw_q[k] == GW_INSVC);
    end
    set_pend = trig & ~pend & ~insvc;
  end

  always_comb begin
    claim_hit = '0;
    cmpl_hit  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      claim_hit[k] = rd && word == W_CLAIM && best_q == 5'(k + 1) && pend[k];
      cmpl_hit[k]  = wr && word == W_CLAIM && wb_dat_i[4:0] == 5'(k + 1) && insvc[k];
    end
  end

  // Gateway next state.
  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      gw_d[k] = gw_q[k];
      case (gw_q[k])
        GW_IDLE:  if (trig[k])      gw_d[k] = GW_PEND;
        GW_PEND:  if (claim_hit[k]) gw_d[k] = GW_INSVC;
        GW_INSVC: if (cmpl_hit[k])  gw_d[k] = GW_IDLE;
        default:                    gw_d[k] = GW_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      prio_d[k] = prio_q[k];
      if (wr && sel_prio && prio_idx == 10'(k + 1)) prio_d[k] = wb_dat_i[PRIO_W-1:0];
    end
    en_d  = (wr && word == W_EN)  ? wb_dat_i[NUM_SRC-1:0] : en_q;
    thr_d = (wr && word == W_THR) ? wb_dat_i[PRIO_W-1:0]  : thr_q;
  end

  // Strict '>' while scanning upward keeps the lowest ID on a priority tie.
  always_comb begin
    best_d = '0;
    best_p = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (pend[k] && en_q[k] && prio_q[k] > thr_q && (!found || prio_q[k] > best_p)) begin
        found  = 1'b1;
        best_p = prio_q[k];
        best_d = 5'(k + 1);
      end
    end
    int_d = (best_q != 5'd0) & csr_mstatus_i[3] & csr_mie_i[11];
  end

  always_comb begin
    rdata = '0;
    if (sel_prio) begin
      for (int k = 0; k < NUM_SRC; k++)
        if (prio_idx == 10'(k + 1)) rdata[PRIO_W-1:0] = prio_q[k];
    end else if (word == W_PEND) begin
      rdata[NUM_SRC-1:0] = pend;
    end else if (word == W_EN) begin
      rdata[NUM_SRC-1:0] = en_q;
    end else if (word == W_THR) begin
      rdata[PRIO_W-1:0] = thr_q;
    end else if (word == W_CLAIM) begin
      rdata[4:0] = best_q;
`ifdef PLIC_EDGE_EN
    end else if (word == W_EDGE) begin
      rdata[NUM_SRC-1:0] = emode_q;
`endif
    end
    ack_d = wb_cyc_i & wb_stb_i & ~ack_q;
    dat_d = rd ? rdata : 32'd0;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      en_q   <= '0;
      thr_q  <= '0;
      best_q <= '0;
      int_q  <= 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
        prio_q[k] <= '0;
        gw_q[k]   <= GW_IDLE;
      end
    end else begin
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      en_q   <= en_d;
      thr_q  <= thr_d;
      best_q <= best_d;
      int_q  <= int_d;
      for (int k = 0; k < NUM_SRC; k++) begin
        prio_q[k] <= prio_d[k];
        gw_q[k]   <= gw_d[k];
      end
    end
  end

  assign wb_ack_o    = ack_q;
  assign wb_dat_o    = dat_q;
  assign interrupt_o = int_q;
  assign exc_code_o  = int_q ? 31'd11 : 31'd0;

endmodule

// File: tb/tb_plic_n.sv
// Scoreboard bench for plic_n: read expectations are queued at issue and compared when the bus acks.
module tb_plic_n;
  localparam logic [31:0] BASE  = 32'h0C000000;
  localparam logic [31:0] O_PND = 32'h001000;
  localparam logic [31:0] O_EDG = 32'h001004;
  localparam logic [31:0] O_EN  = 32'h002000;
  localparam logic [31:0] O_THR = 32'h200000;
  localparam logic [31:0] O_CLM = 32'h200004;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n_i;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o;
  logic [6:0]  irq_i;
  logic [31:0] csr_mstatus_i, csr_mie_i;
  logic        interrupt_o;
  logic [30:0] exc_code_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  plic_n #(.NUM_SRC(7), .PRIO_W(3), .BASE_ADDR(BASE)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i),
    .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o), .irq_i(irq_i), .csr_mstatus_i(csr_mstatus_i),
    .csr_mie_i(csr_mie_i), .interrupt_o(interrupt_o), .exc_code_o(exc_code_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge wb_clk_i); #1; end
  endtask

  task automatic bus_xfer(input logic [31:0] off, input logic we, input logic [31:0] dat);
    bit          got_ack = 1'b0;
    string       t;
    logic [31:0] e;
    wb_adr_i = BASE + off; wb_we_i = we; wb_dat_i = dat;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge wb_clk_i); #1;
      if (wb_ack_o) begin got_ack = 1'b1; break; end
    end
    if (!got_ack) chk("ack_timeout", {31'b0, wb_ack_o}, 32'd1);
    if (!we) begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      if (got_ack) chk(t, wb_dat_o, e);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    cyc(1);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] dat);
    bus_xfer(off, 1'b1, dat);
  endtask

  task automatic rd(input logic [31:0] off, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    bus_xfer(off, 1'b0, 32'd0);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, {31'b0, interrupt_o}, {31'b0, exp});
    chk({tag, "_exc"}, {1'b0, exc_code_o}, exp ? 32'd11 : 32'd0);
  endtask

  initial begin
    wb_rst_n_i = 1'b0; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = 4'hF;
    wb_we_i = 1'b0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0; irq_i = '0;
    csr_mstatus_i = 32'h8; csr_mie_i = 32'h800;
    cyc(3);
    chk("rst_ack", {31'b0, wb_ack_o}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk_irq("rst_irq", 1'b0);
    @(negedge wb_clk_i); wb_rst_n_i = 1'b1;
    cyc(2);

    for (int k = 0; k <= 7; k++) rd(32'(4 * k), 32'd0, $sformatf("rst_prio%0d", k));
    rd(O_PND, 32'd0, "rst_pend");
    rd(O_EN,  32'd0, "rst_en");
    rd(O_THR, 32'd0, "rst_thr");
    rd(O_CLM, 32'd0, "rst_claim");
    rd(32'h3000, 32'd0, "unmapped_rd");
    wr(32'h0, 32'h7); rd(32'h0, 32'd0, "prio0_wr_dropped");
    wr(32'h3000, 32'hFF); rd(32'h3000, 32'd0, "unmapped_wr");

    // Latency and enable masking: only ID 3 enabled although ID 1 has equal priority.
    wr(32'h4, 2); wr(32'hC, 2); wr(O_THR, 1); wr(O_EN, 32'h4);
    rd(32'h4, 32'd2, "prio1_rb");
    irq_i = 7'h05;
    cyc(1); chk_irq("lat_e1", 1'b0);
    cyc(1); chk_irq("lat_e2", 1'b0);
    cyc(1); chk_irq("lat_e3", 1'b1);
    rd(O_CLM, 32'd3, "claim_en_mask");
    rd(O_PND, 32'h1, "pend_after_claim");
    rd(O_CLM, 32'd0, "claim_none");
    wr(O_CLM, 3);
    rd(O_PND, 32'h5, "repend_after_cmpl");

    // Priority order, no re-pend while in service.
    wr(O_EN, 32'h5); wr(32'hC, 5);
    rd(O_CLM, 32'd3, "claim_hi");
    rd(O_CLM, 32'd1, "claim_lo");
    rd(O_CLM, 32'd0, "claim_empty");
    rd(O_PND, 32'h0, "pend_insvc");
    wr(O_CLM, 0); wr(O_CLM, 9);
    rd(O_PND, 32'h0, "cmpl_bad_id");
    wr(O_CLM, 1); rd(O_PND, 32'h1, "cmpl1");
    wr(O_CLM, 3); rd(O_PND, 32'h5, "cmpl3");
    irq_i = '0;
    rd(O_CLM, 32'd3, "drain3"); rd(O_CLM, 32'd1, "drain1");
    wr(O_CLM, 3); wr(O_CLM, 1);
    rd(O_PND, 32'h0, "drained");
    cyc(3); chk_irq("drained_irq", 1'b0);

    // Threshold and core gating.
    wr(32'h8, 1); wr(O_EN, 32'h2); irq_i = 7'h02;
    cyc(5); chk_irq("thr_block", 1'b0);
    rd(O_PND, 32'h2, "thr_pend");
    wr(O_THR, 0);
    cyc(4); chk_irq("thr_open", 1'b1);
    csr_mstatus_i = 32'h0;
    cyc(3); chk_irq("mie_off", 1'b0);
    rd(O_PND, 32'h2, "mie_off_pend");
    csr_mstatus_i = 32'h8; csr_mie_i = 32'h0;
    cyc(3); chk_irq("meie_off", 1'b0);
    csr_mie_i = 32'h800;
    cyc(3); chk_irq("gate_on", 1'b1);

    // Asynchronous reset in the middle of a bus access.
    wb_adr_i = BASE + O_THR; wb_dat_i = 32'h5; wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    #2 wb_rst_n_i = 1'b0; irq_i = '0;
    #1 chk("midrst_ack", {31'b0, wb_ack_o}, 32'd0);
    chk_irq("midrst_irq", 1'b0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge wb_clk_i); wb_rst_n_i = 1'b1;
    cyc(2);
    rd(O_THR, 32'd0, "midrst_thr");
    rd(O_EN, 32'd0, "midrst_en");
    rd(32'h8, 32'd0, "midrst_prio2");
    rd(O_PND, 32'd0, "midrst_pend");

    // Access withdrawn before the ack edge has no effect.
    wb_adr_i = BASE + O_THR; wb_dat_i = 32'h6; wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    #3 wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    cyc(2);
    rd(O_THR, 32'd0, "dropped_wr");

`ifdef PLIC_EDGE_EN
    wr(O_EDG, 32'h1); rd(O_EDG, 32'h1, "edge_rb");
    wr(32'h4, 3); wr(O_EN, 32'h1);
    irq_i[0] = 1'b1; cyc(1); irq_i[0] = 1'b0; cyc(2);
    rd(O_PND, 32'h1, "edge_pend");
    rd(O_CLM, 32'd1, "edge_claim");
    for (int p = 0; p < 2; p++) begin
      irq_i[0] = 1'b1; cyc(1); irq_i[0] = 1'b0; cyc(2);
    end
    rd(O_PND, 32'h0, "edge_insvc");
    wr(O_CLM, 1);
    rd(O_PND, 32'h1, "edge_latched");
    rd(O_CLM, 32'd1, "edge_claim2");
    wr(O_CLM, 1); cyc(3);
    rd(O_PND, 32'h0, "edge_once");
`else
    wr(O_EDG, 32'h7F); rd(O_EDG, 32'h0, "edge_reg_absent");
    irq_i[0] = 1'b1; cyc(1); irq_i[0] = 1'b0; cyc(2);
    rd(O_PND, 32'h1, "level_pend_held");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
